// File: rtl/ap_job_ctrl.sv
// Job sequencer for an associative processor: clears the AP columns, streams operand pairs in,
// runs the compute with an irq/timeout watchdog, then streams the result column out.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | waiting for start; an illegal cmd pulses error
// CLR0     | clear internal column 0
// CLR1     | clear internal column 1
// LD_A     | op_ready offered; the handshake queues the column-0 write
// LD_B     | column-0 write visible; queue the column-1 write
// COMP     | compute enabled; wait for an irq rising edge or timeout
// RD_ISSUE | read strobe to column C at the current index
// RD_WAIT  | AP read data is valid; capture it into res_data
// RD_HOLD  | result offered until res_ready
// FIN      | done pulse
module ap_job_ctrl #(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 512,
    parameter int ADDR_W     = 10,
    parameter int TIMEOUT    = 4096
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           cmd_in,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [WORD_SIZE-1:0] op_a,
    input  logic [WORD_SIZE-1:0] op_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WORD_SIZE-1:0] res_data,
    output logic [ADDR_W-1:0]    res_idx,
    output logic [ADDR_W-1:0]    ap_addr,
    output logic [WORD_SIZE-1:0] ap_data,
    output logic                 ap_rst,
    output logic                 ap_mode,
    output logic [2:0]           ap_cmd,
    output logic [1:0]           ap_sel_col,
    output logic                 ap_sel_internal_col,
    output logic                 ap_write_en,
    output logic                 ap_read_en,
    input  logic [WORD_SIZE-1:0] ap_data_out,
    input  logic                 ap_state_irq
);

    typedef enum logic [3:0] {
        IDLE, CLR0, CLR1, LD_A, LD_B, COMP, RD_ISSUE, RD_WAIT, RD_HOLD, FIN
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CELL_QUANT - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t               state;
    logic [ADDR_W-1:0]    idx;
    logic [CNT_W-1:0]     cyc_cnt;
    logic                 irq_q;
    logic [WORD_SIZE-1:0] op_b_q;
    logic                 irq_rise;

    assign irq_rise = ap_state_irq & ~irq_q;

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state               <= IDLE;
            idx                 <= '0;
            cyc_cnt             <= '0;
            irq_q               <= 1'b0;
            op_b_q              <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            error               <= 1'b0;
            op_ready            <= 1'b0;
            res_valid           <= 1'b0;
            res_data            <= '0;
            res_idx             <= '0;
            ap_addr             <= '0;
            ap_data             <= '0;
            ap_rst              <= 1'b0;
            ap_mode             <= 1'b0;
            ap_cmd              <= '0;
            ap_sel_col          <= '0;
            ap_sel_internal_col <= 1'b0;
            ap_write_en         <= 1'b0;
            ap_read_en          <= 1'b0;
        end else begin
            irq_q <= ap_state_irq;
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cmd_in <= 3'd3) begin
                            ap_cmd              <= cmd_in;
                            idx                 <= '0;
                            busy                <= 1'b1;
                            ap_rst              <= 1'b1;
                            ap_sel_internal_col <= 1'b0;
                            state               <= CLR0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                CLR0: begin
                    ap_sel_internal_col <= 1'b1;
                    state               <= CLR1;
                end
                CLR1: begin
                    ap_rst              <= 1'b0;
                    ap_sel_internal_col <= 1'b0;
                    op_ready            <= 1'b1;
                    state               <= LD_A;
                end
                LD_A: begin
                    if (op_valid && op_ready) begin
                        op_b_q      <= op_b;
                        ap_data     <= op_a;
                        ap_addr     <= idx;
                        ap_sel_col  <= 2'd0;
                        ap_write_en <= 1'b1;
                        op_ready    <= 1'b0;
                        state       <= LD_B;
                    end else begin
                        // ready toggles while idle-waiting so it is never high two cycles running
                        ap_write_en <= 1'b0;
                        op_ready    <= ~op_ready;
                    end
                end
                LD_B: begin
                    ap_data     <= op_b_q;
                    ap_addr     <= idx;
                    ap_sel_col  <= 2'd1;
                    ap_write_en <= 1'b1;
                    if (idx == LAST_IDX) begin
                        cyc_cnt <= '0;
                        state   <= COMP;
                    end else begin
                        idx      <= idx + 1'b1;
                        op_ready <= 1'b1;
                        state    <= LD_A;
                    end
                end
                COMP: begin
                    // the last column-1 write drains in the first COMP cycle; ap_mode follows it
                    ap_write_en <= 1'b0;
                    if (irq_rise) begin
                        ap_mode    <= 1'b0;
                        idx        <= '0;
                        ap_addr    <= '0;
                        ap_sel_col <= 2'd2;
                        ap_read_en <= 1'b1;
                        state      <= RD_ISSUE;
                    end else if (cyc_cnt == CNT_LAST) begin
                        ap_mode <= 1'b0;
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        ap_mode <= 1'b1;
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                RD_ISSUE: begin
                    ap_read_en <= 1'b0;
                    state      <= RD_WAIT;
                end
                RD_WAIT: begin
                    res_data  <= ap_data_out;
                    res_idx   <= idx;
                    res_valid <= 1'b1;
                    state     <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            idx        <= idx + 1'b1;
                            ap_addr    <= idx + 1'b1;
                            ap_read_en <= 1'b1;
                            state      <= RD_ISSUE;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ap_job_ctrl.sv
// Bench for ap_job_ctrl with a small behavioural AP model (4-word columns, irq a few cycles
// after compute starts); table of jobs plus directed error, stall, timeout and reset sequences.
module tb_ap_job_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] cmd_in = '0;
    logic       busy, done, error;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [7:0] op_a = '0, op_b = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic [1:0] res_idx, ap_addr;
    logic [7:0] ap_data;
    logic       ap_rst, ap_mode;
    logic [2:0] ap_cmd;
    logic [1:0] ap_sel_col;
    logic       ap_sel_internal_col, ap_write_en, ap_read_en;
    logic [7:0] ap_data_out = '0;
    logic       ap_state_irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ap_job_ctrl #(.WORD_SIZE(8), .CELL_QUANT(4), .ADDR_W(2), .TIMEOUT(16)) dut (
        .CLK100MHZ(clk), .rst(rst), .start(start), .cmd_in(cmd_in),
        .busy(busy), .done(done), .error(error),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
        .ap_addr(ap_addr), .ap_data(ap_data), .ap_rst(ap_rst), .ap_mode(ap_mode),
        .ap_cmd(ap_cmd), .ap_sel_col(ap_sel_col), .ap_sel_internal_col(ap_sel_internal_col),
        .ap_write_en(ap_write_en), .ap_read_en(ap_read_en),
        .ap_data_out(ap_data_out), .ap_state_irq(ap_state_irq)
    );

    // behavioural AP
    logic [7:0] col_a [4];
    logic [7:0] col_b [4];
    logic [7:0] col_c [4];
    logic       mode_q = 1'b0;
    logic       irq_on = 1'b0;
    logic       force_irq = 1'b0;
    int         irq_cnt = 0;

    assign ap_state_irq = force_irq | irq_on;

    always @(posedge clk) begin
        if (ap_rst) begin
            for (int i = 0; i < 4; i++) begin
                col_a[i] <= '0;
                col_b[i] <= '0;
                col_c[i] <= '0;
            end
        end else if (ap_write_en) begin
            if (ap_sel_col == 2'd0) col_a[ap_addr] <= ap_data;
            else if (ap_sel_col == 2'd1) col_b[ap_addr] <= ap_data;
        end
        if (ap_read_en) ap_data_out <= col_c[ap_addr];
        mode_q <= ap_mode;
        if (ap_mode && !mode_q) begin
            irq_cnt <= 5;
            for (int i = 0; i < 4; i++) begin
                case (ap_cmd)
                    3'd0:    col_c[i] <= col_a[i] | col_b[i];
                    3'd1:    col_c[i] <= col_a[i] ^ col_b[i];
                    3'd2:    col_c[i] <= col_a[i] & col_b[i];
                    default: col_c[i] <= ~col_a[i];
                endcase
            end
        end else if (irq_cnt != 0) begin
            irq_cnt <= irq_cnt - 1;
        end
        if (!ap_mode) irq_on <= 1'b0;
        else if (irq_cnt == 1) irq_on <= 1'b1;
    end

    typedef struct {
        logic [2:0] cmd;
        logic [7:0] a   [4];
        logic [7:0] b   [4];
        logic [7:0] exp [4];
    } job_t;
    job_t vec [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({busy, done, error, op_ready, res_valid, res_data, res_idx, ap_addr, ap_data,
                    ap_rst, ap_mode, ap_cmd, ap_sel_col, ap_sel_internal_col, ap_write_en,
                    ap_read_en});
    endfunction

    // op_ready never high twice in a row; back-to-back writes alternate columns
    logic       prev_ready = 1'b0;
    logic       prev_we = 1'b0;
    logic [1:0] prev_col = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_ready <= 1'b0;
            prev_we    <= 1'b0;
        end else begin
            if (op_ready) chk("op_ready_spacing", 64'(prev_ready), 64'd0);
            if (ap_write_en && prev_we) chk("write_col_alternates", 64'(ap_sel_col == prev_col), 64'd0);
            prev_ready <= op_ready;
            prev_we    <= ap_write_en;
            prev_col   <= ap_sel_col;
        end
    end

    // mode 0: normal job, mode 1: expect timeout (irq held high), mode 2: reset during first LD_B
    task automatic run_job(input int v, input int stall_idx, input int mode);
        int k, r, cyc, done_cnt, err_cnt, stall_left, last_wr, err_cyc;
        logic [7:0] hold_data;
        logic [1:0] hold_idx;
        logic       mode_at_err;
        bit         fin;
        k = 0; r = 0; cyc = 0; done_cnt = 0; err_cnt = 0; stall_left = 3;
        last_wr = -100; err_cyc = 0; mode_at_err = 1'b1; fin = 0;
        hold_data = '0; hold_idx = '0;
        force_irq = (mode == 1);
        @(negedge clk);
        cmd_in = vec[v].cmd;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 300) begin
            if (mode == 2 && ap_write_en && ap_sel_col == 2'd0) begin
                rst = 1'b1;
                op_valid = 1'b0;
                @(negedge clk);
                chk("reset_mid_ld_b_outputs", outs(), 64'd0);
                rst = 1'b0;
                fin = 1;
            end else begin
                op_valid = (k < 4);
                op_a = vec[v].a[k % 4];
                op_b = vec[v].b[k % 4];
                res_ready = 1'b1;
                if (res_valid && int'(res_idx) == stall_idx && stall_left > 0) begin
                    if (stall_left == 3) begin
                        hold_data = res_data;
                        hold_idx  = res_idx;
                    end else begin
                        chk("stall_res_data", 64'(res_data), 64'(hold_data));
                        chk("stall_res_idx", 64'(res_idx), 64'(hold_idx));
                    end
                    chk("stall_no_read", 64'(ap_read_en), 64'd0);
                    res_ready = 1'b0;
                    stall_left--;
                end
                if (op_valid && op_ready) k++;
                if (res_valid && res_ready) begin
                    chk("res_idx", 64'(res_idx), 64'(r));
                    chk("res_data", 64'(res_data), 64'(vec[v].exp[r % 4]));
                    r++;
                end
                if (ap_write_en && ap_sel_col == 2'd1 && ap_addr == 2'd3) last_wr = cyc;
                if (done) done_cnt++;
                if (error) begin
                    err_cnt++;
                    err_cyc = cyc;
                    mode_at_err = ap_mode;
                end
                if ((done_cnt > 0 || err_cnt > 0) && !busy && !done && !error) fin = 1;
                @(negedge clk);
                cyc++;
            end
        end
        op_valid  = 1'b0;
        res_ready = 1'b0;
        force_irq = 1'b0;
        if (cyc >= 300) chk("job_cycle_budget", 64'(cyc), 64'd0);
        if (mode == 0) begin
            chk("result_count", 64'(r), 64'd4);
            chk("done_pulses", 64'(done_cnt), 64'd1);
            chk("error_pulses", 64'(err_cnt), 64'd0);
            for (int i = 0; i < 4; i++) begin
                chk("col_a_loaded", 64'(col_a[i]), 64'(vec[v].a[i]));
                chk("col_b_loaded", 64'(col_b[i]), 64'(vec[v].b[i]));
            end
        end else if (mode == 1) begin
            chk("timeout_error_pulses", 64'(err_cnt), 64'd1);
            chk("timeout_no_done", 64'(done_cnt), 64'd0);
            chk("timeout_latency", 64'(err_cyc - last_wr), 64'd16);
            chk("timeout_mode_low", 64'(mode_at_err), 64'd0);
            chk("timeout_no_results", 64'(r), 64'd0);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int strobes;
        vec[0].cmd = 3'd0;
        vec[0].a   = '{8'h01, 8'h02, 8'h04, 8'h08};
        vec[0].b   = '{8'h10, 8'h20, 8'h40, 8'h80};
        vec[0].exp = '{8'h11, 8'h22, 8'h44, 8'h88};
        vec[1].cmd = 3'd3;
        vec[1].a   = '{8'h00, 8'hFF, 8'h0F, 8'hA5};
        vec[1].b   = '{8'h11, 8'h22, 8'h33, 8'h44};
        vec[1].exp = '{8'hFF, 8'h00, 8'hF0, 8'h5A};
        vec[2].cmd = 3'd1;
        vec[2].a   = '{8'hFF, 8'h0F, 8'hAA, 8'h00};
        vec[2].b   = '{8'h0F, 8'h0F, 8'h55, 8'h3C};
        vec[2].exp = '{8'hF0, 8'h00, 8'hFF, 8'h3C};
        vec[3].cmd = 3'd2;
        vec[3].a   = '{8'hFF, 8'hF0, 8'hAA, 8'h13};
        vec[3].b   = '{8'h0F, 8'h3C, 8'h55, 8'hFF};
        vec[3].exp = '{8'h0F, 8'h30, 8'h00, 8'h13};

        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", outs(), 64'd0);

        for (int v = 0; v < 4; v++) run_job(v, -1, 0);

        // illegal command
        @(negedge clk);
        cmd_in = 3'd5;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("illegal_cmd_error", 64'(error), 64'd1);
        chk("illegal_cmd_busy", 64'(busy), 64'd0);
        strobes = 0;
        repeat (4) begin
            @(negedge clk);
            if (ap_write_en || ap_read_en || ap_rst || ap_mode || error || busy) strobes++;
        end
        chk("illegal_cmd_quiet", 64'(strobes), 64'd0);

        run_job(2, 2, 0);
        run_job(0, -1, 1);
        run_job(1, -1, 2);
        chk("idle_after_abort", 64'(busy), 64'd0);
        run_job(3, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
